cpu_mem_responder: RTL and testbench
====================================

Name: cpu_mem_responder

Overview:
Synthesizable memory-side responder for cpu_32bit: it serves instruction fetch and data load/store in place of the behavioural bench memories. It holds separate instruction and data word arrays, plus a loader port that fills them while the CPU is held in reset. After loading, it releases the CPU and serves accesses until the CPU halts. It also flags illegal accesses and counts traffic, so it can back both simulation and FPGA bring-up.

Parameters:
AW, 8, word-address width; each array holds 2**AW 32-bit words.
CNT_W, 16, width of the saturating access counters.
HALT_WORD, 32'hF800_0000, word returned on an illegal fetch (opcode 5'b11111 = HALT).

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
load_valid  in  1  loader beat valid.
load_ready  out  1  loader beat accepted when load_valid && load_ready.
load_sel  in  1  0 = instruction array, 1 = data array.
load_addr  in  AW  word index.
load_data  in  32  word to store.
load_last  in  1  final beat of the program image.
reload  in  1  single-cycle pulse: DONE -> LOAD.
cpu_rst_n  out  1  drives the CPU reset, active-low (CPU rst = ~cpu_rst_n).
pc  in  32  CPU byte address for fetch.
instr  out  32  fetched instruction, combinational.
mem_addr  in  32  CPU data byte address.
mem_data_out  in  32  CPU store data.
mem_we  in  1  store strobe.
mem_re  in  1  load strobe.
mem_data_in  out  32  load data to the CPU, combinational.
cpu_halted  in  1  CPU halt indication.
state  out  2  LOAD=0, RUN=1, DONE=2.
fault  out  1  sticky illegal-access flag.
fault_addr  out  32  byte address of the first fault.
rd_count  out  CNT_W  accepted loads, saturating.
wr_count  out  CNT_W  accepted stores, saturating.

Behaviour:
- Reset (asynchronous, rst_n=0) forces:
  - state=LOAD, cpu_rst_n=0, load_ready=1;
  - fault=0, fault_addr=0, rd_count=0, wr_count=0.
  - Array contents are not reset.
- LOAD:
  - load_ready=1.
  - An accepted beat writes load_data into the array chosen by load_sel at load_addr on that edge.
  - An accepted beat with load_last=1 moves to RUN on the same edge; cpu_rst_n goes to 1 from the next cycle.
  - CPU ports are ignored; instr=HALT_WORD; mem_data_in=0.
- RUN:
  - load_ready=0.
  - Fetch: instr = imem[pc[AW+1:2]] combinationally.
  - If pc[1:0]!=0 or pc[31:AW+2]!=0, instr=HALT_WORD, so the CPU halts on a bad PC. This is not a fault.
  - A data access is illegal when any of these hold:
    - mem_addr[1:0]!=0;
    - mem_addr[31:AW+2]!=0;
    - mem_we && mem_re in the same cycle.
  - On an illegal access: no array write; mem_data_in=0; fault is set on the edge.
  - fault_addr captures mem_addr only when fault was 0 (first fault wins).
  - Legal store: dmem[mem_addr[AW+1:2]] <= mem_data_out on the edge; wr_count+1.
  - Legal load: mem_data_in = dmem[...] combinationally; rd_count+1 on the edge.
  - When mem_re=0, mem_data_in=0.
  - cpu_halted=1 -> DONE on the next edge. Any access presented in that same cycle is still served.
- DONE:
  - cpu_rst_n stays 1, so the register file remains observable.
  - Stores are ignored and counters are frozen.
  - Loads and fetches are still served, for post-mortem readout.
  - reload=1 -> LOAD on the next edge, clearing counters and fault; cpu_rst_n=0 from that edge.
  - reload in LOAD or RUN is ignored.
- Counters hold at 2**CNT_W-1 instead of wrapping.
- Reset asserted mid-RUN returns to LOAD immediately (asynchronously) with cpu_rst_n=0.
- Two-flop reset synchronisation is outside this block.

Decomposition:
- Shared package cpu_mem_pkg holds:
  - the state encoding (ST_LOAD, ST_RUN, ST_DONE);
  - HALT opcode 5'b11111 and HALT_WORD;
  - the word-index extraction convention (addr[AW+1:2]).
- One sub-module, mem_word_array: 2**AW x 32, one synchronous write port, one asynchronous read port. Instantiate it twice (imem, dmem).
- The loader write and the CPU store to dmem are muxed by state in the top level; they are never simultaneous.

Test Plan:
1. Load imem[0..2] with the third beat load_last=1 -> state=RUN after that edge; cpu_rst_n=1 the next cycle; load_ready=0; instr at pc=0x4 equals the second word loaded.
2. In RUN, store 0xDEADBEEF at mem_addr=0x10, then load from 0x10 -> mem_data_in=0xDEADBEEF; wr_count=1, rd_count=1; fault=0.
3. Store at 0x12, then at 0x400 -> fault=1; fault_addr=0x12 (unchanged by the second); dmem[4] unchanged; wr_count unchanged.
4. pc=0x400, then pc=0x6 -> instr=0xF8000000 both times; fault stays 0.
5. Assert cpu_halted -> state=DONE; a store to 0x10 of 0x1 is ignored (load still returns 0xDEADBEEF); pulse reload -> state=LOAD, cpu_rst_n=0, counters 0, fault 0.
6. Drop rst_n mid-RUN -> state=LOAD and cpu_rst_n=0 without waiting for a clock edge; previously loaded imem/dmem words still read back after a second load_last.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared encodings for the cpu_32bit memory responder.
// Holds the sequencer states, the HALT word and the byte-to-word address convention.
package cpu_mem_pkg;

  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [4:0]  HALT_OPCODE    = 5'b11111;
  localparam logic [31:0] HALT_WORD_DFLT = {HALT_OPCODE, 27'd0};

  // Word index of a byte address is addr[AW+1:2]. Callers take the low AW bits
  // as the array index; anything above that is out of range.
  function automatic logic [29:0] word_index(input logic [31:0] addr);
    return addr[31:2];
  endfunction

endpackage

// File: rtl/mem_word_array.sv
// 2**AW x 32 word store: one synchronous write port and one asynchronous read port.
// Contents are deliberately not reset, so they survive a CPU reset or reload.
module mem_word_array #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [2**AW];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/cpu_mem_responder.sv
// Memory-side responder for cpu_32bit: loads the program image with the CPU held in
// reset, then serves fetch and load/store, flags illegal accesses and counts traffic.
//
// state   | meaning
// LOAD    | loader port owns both arrays, CPU held in reset
// RUN     | CPU released, fetch/load/store served, faults and counters live
// DONE    | CPU halted, loads/fetches still served, stores ignored, counters frozen
module cpu_mem_responder
  import cpu_mem_pkg::*;
#(
  parameter int          AW        = 8,
  parameter int          CNT_W     = 16,
  parameter logic [31:0] HALT_WORD = HALT_WORD_DFLT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             load_sel,
  input  logic [AW-1:0]    load_addr,
  input  logic [31:0]      load_data,
  input  logic             load_last,
  input  logic             reload,
  output logic             cpu_rst_n,
  input  logic [31:0]      pc,
  output logic [31:0]      instr,
  input  logic [31:0]      mem_addr,
  input  logic [31:0]      mem_data_out,
  input  logic             mem_we,
  input  logic             mem_re,
  output logic [31:0]      mem_data_in,
  input  logic             cpu_halted,
  output logic [1:0]       state,
  output logic             fault,
  output logic [31:0]      fault_addr,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W-1:0] wr_count
);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic             r_cpu_rst_n;
  logic             r_fault;
  logic [31:0]      r_fault_addr;
  logic [CNT_W-1:0] r_rd_count;
  logic [CNT_W-1:0] r_wr_count;

  logic        w_in_load;
  logic        w_in_run;
  logic        w_serving;
  logic        w_load_beat;
  logic        w_reload_go;
  logic [29:0] w_pc_word;
  logic [29:0] w_d_word;
  logic        w_pc_ok;
  logic        w_d_bad;
  logic        w_store_ok;
  logic        w_load_ok;
  logic        w_fault_ev;

  logic          w_imem_we;
  logic [31:0]   w_imem_rdata;
  logic          w_dmem_we;
  logic [AW-1:0] w_dmem_waddr;
  logic [31:0]   w_dmem_wdata;
  logic [31:0]   w_dmem_rdata;

  assign w_in_load   = (r_state == ST_LOAD);
  assign w_in_run    = (r_state == ST_RUN);
  assign w_serving   = (r_state == ST_RUN) || (r_state == ST_DONE);
  assign w_load_beat = w_in_load && load_valid;
  assign w_reload_go = (r_state == ST_DONE) && reload;

  assign w_pc_word = word_index(pc);
  assign w_d_word  = word_index(mem_addr);

  // A bad PC is answered with HALT rather than flagged, so the CPU stops cleanly.
  assign w_pc_ok = (pc[1:0] == 2'b00) && !(|w_pc_word[29:AW]);

  assign w_d_bad = (|mem_addr[1:0]) || (|w_d_word[29:AW]) || (mem_we && mem_re);

  assign w_store_ok = w_in_run && mem_we && !w_d_bad;
  assign w_load_ok  = w_serving && mem_re && !w_d_bad;
  assign w_fault_ev = w_in_run && (mem_we || mem_re) && w_d_bad;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_LOAD: if (w_load_beat && load_last) w_state_nxt = ST_RUN;
      ST_RUN:  if (cpu_halted)               w_state_nxt = ST_DONE;
      ST_DONE: if (reload)                   w_state_nxt = ST_LOAD;
      default:                               w_state_nxt = ST_LOAD;
    endcase
  end

  // CPU reset is a flop rather than a state decode so it cannot glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_LOAD;
      r_cpu_rst_n <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cpu_rst_n <= (w_state_nxt != ST_LOAD);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fault      <= 1'b0;
      r_fault_addr <= 32'd0;
    end else if (w_reload_go) begin
      r_fault      <= 1'b0;
      r_fault_addr <= 32'd0;
    end else if (w_fault_ev) begin
      r_fault <= 1'b1;
      if (!r_fault) r_fault_addr <= mem_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_count <= '0;
      r_wr_count <= '0;
    end else if (w_reload_go) begin
      r_rd_count <= '0;
      r_wr_count <= '0;
    end else begin
      if (w_in_run && w_load_ok && (r_rd_count != '1)) r_rd_count <= r_rd_count + 1'b1;
      if (w_store_ok && (r_wr_count != '1))            r_wr_count <= r_wr_count + 1'b1;
    end
  end

  // Loader and CPU store never overlap: the loader only writes in LOAD, stores only in RUN.
  assign w_imem_we    = w_load_beat && !load_sel;
  assign w_dmem_we    = (w_load_beat && load_sel) || w_store_ok;
  assign w_dmem_waddr = w_in_load ? load_addr : w_d_word[AW-1:0];
  assign w_dmem_wdata = w_in_load ? load_data : mem_data_out;

  mem_word_array #(.AW(AW)) u_imem (
    .clk     (clk),
    .i_we    (w_imem_we),
    .i_waddr (load_addr),
    .i_wdata (load_data),
    .i_raddr (w_pc_word[AW-1:0]),
    .o_rdata (w_imem_rdata)
  );

  mem_word_array #(.AW(AW)) u_dmem (
    .clk     (clk),
    .i_we    (w_dmem_we),
    .i_waddr (w_dmem_waddr),
    .i_wdata (w_dmem_wdata),
    .i_raddr (w_d_word[AW-1:0]),
    .o_rdata (w_dmem_rdata)
  );

  assign instr       = (w_serving && w_pc_ok) ? w_imem_rdata : HALT_WORD;
  assign mem_data_in = w_load_ok ? w_dmem_rdata : 32'd0;

  assign load_ready = w_in_load;
  assign cpu_rst_n  = r_cpu_rst_n;
  assign state      = r_state;
  assign fault      = r_fault;
  assign fault_addr = r_fault_addr;
  assign rd_count   = r_rd_count;
  assign wr_count   = r_wr_count;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench for cpu_mem_responder: table of RUN/DONE vectors with hand-computed
// expectations, plus hand sequences for load, reload and asynchronous reset.
module tb_cpu_mem_responder;

  localparam logic [31:0] HALT = 32'hF800_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_valid, load_ready, load_sel, load_last, reload;
  logic [7:0]  load_addr;
  logic [31:0] load_data;
  logic        cpu_rst_n;
  logic [31:0] pc, instr, mem_addr, mem_data_out, mem_data_in;
  logic        mem_we, mem_re, cpu_halted;
  logic [1:0]  state;
  logic        fault;
  logic [31:0] fault_addr;
  logic [15:0] rd_count, wr_count;

  int n_vec = 0;
  int n_err = 0;

  cpu_mem_responder dut (
    .clk(clk), .rst_n(rst_n),
    .load_valid(load_valid), .load_ready(load_ready), .load_sel(load_sel),
    .load_addr(load_addr), .load_data(load_data), .load_last(load_last),
    .reload(reload), .cpu_rst_n(cpu_rst_n),
    .pc(pc), .instr(instr),
    .mem_addr(mem_addr), .mem_data_out(mem_data_out), .mem_we(mem_we), .mem_re(mem_re),
    .mem_data_in(mem_data_in), .cpu_halted(cpu_halted),
    .state(state), .fault(fault), .fault_addr(fault_addr),
    .rd_count(rd_count), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, addr, wdata;
    logic        we, re, halt, rld;
    logic [31:0] e_instr, e_mdi;
    logic [1:0]  e_state;
    logic        e_fault;
    logic [31:0] e_faddr;
    logic [15:0] e_rd, e_wr;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_cpu();
    pc = 32'd0; mem_addr = 32'd0; mem_data_out = 32'd0;
    mem_we = 1'b0; mem_re = 1'b0; cpu_halted = 1'b0; reload = 1'b0;
  endtask

  task automatic load_beat(input logic sel, input logic [7:0] a, input logic [31:0] d,
                           input logic last);
    @(negedge clk);
    load_valid = 1'b1; load_sel = sel; load_addr = a; load_data = d; load_last = last;
    #1 chk("load_ready in LOAD", {31'd0, load_ready}, 32'd1);
    @(posedge clk); #1;
    load_valid = 1'b0; load_last = 1'b0;
  endtask

  task automatic check_entered_run(input string tag);
    chk({tag, " state"}, {30'd0, state}, 32'd1);
    chk({tag, " cpu_rst_n"}, {31'd0, cpu_rst_n}, 32'd1);
    chk({tag, " load_ready"}, {31'd0, load_ready}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //           pc        addr       wdata      we   re   hlt  rld  instr        mdi          st    flt  faddr      rd  wr
    tbl[0]  = '{32'h0,   32'h0,   32'h0,        0,0,0,0, 32'h0,        32'h0,        2'd1, 0, 32'h0,  16'd0, 16'd0};
    tbl[0].pc = 32'h4; tbl[0].e_instr = 32'h2222_2222;
    tbl[1]  = '{32'h0,   32'h10,  32'hDEADBEEF, 1,0,0,0, 32'h1111_1111, 32'h0,        2'd1, 0, 32'h0,  16'd0, 16'd1};
    tbl[2]  = '{32'h8,   32'h10,  32'h0,        0,1,0,0, 32'h3333_3333, 32'hDEADBEEF, 2'd1, 0, 32'h0,  16'd1, 16'd1};
    tbl[3]  = '{32'h8,   32'h14,  32'h0,        0,1,0,0, 32'h3333_3333, 32'hCAFEF00D, 2'd1, 0, 32'h0,  16'd2, 16'd1};
    tbl[4]  = '{32'h400, 32'h0,   32'h0,        0,0,0,1, HALT,          32'h0,        2'd1, 0, 32'h0,  16'd2, 16'd1};
    tbl[5]  = '{32'h6,   32'h0,   32'h0,        0,0,0,0, HALT,          32'h0,        2'd1, 0, 32'h0,  16'd2, 16'd1};
    tbl[6]  = '{32'h0,   32'h3FC, 32'hA5A5A5A5, 1,0,0,0, 32'h1111_1111, 32'h0,        2'd1, 0, 32'h0,  16'd2, 16'd2};
    tbl[7]  = '{32'h0,   32'h3FC, 32'h0,        0,1,0,0, 32'h1111_1111, 32'hA5A5A5A5, 2'd1, 0, 32'h0,  16'd3, 16'd2};
    tbl[8]  = '{32'h0,   32'h12,  32'h55,       1,0,0,0, 32'h1111_1111, 32'h0,        2'd1, 1, 32'h12, 16'd3, 16'd2};
    tbl[9]  = '{32'h0,   32'h400, 32'h66,       1,0,0,0, 32'h1111_1111, 32'h0,        2'd1, 1, 32'h12, 16'd3, 16'd2};
    tbl[10] = '{32'h0,   32'h10,  32'h0,        0,1,0,0, 32'h1111_1111, 32'hDEADBEEF, 2'd1, 1, 32'h12, 16'd4, 16'd2};
    tbl[11] = '{32'h0,   32'h10,  32'h77,       1,1,0,0, 32'h1111_1111, 32'h0,        2'd1, 1, 32'h12, 16'd4, 16'd2};
    tbl[12] = '{32'h0,   32'h10,  32'h0,        0,1,0,0, 32'h1111_1111, 32'hDEADBEEF, 2'd1, 1, 32'h12, 16'd5, 16'd2};
    tbl[13] = '{32'h0,   32'h401, 32'h0,        0,1,0,0, 32'h1111_1111, 32'h0,        2'd1, 1, 32'h12, 16'd5, 16'd2};
    tbl[14] = '{32'h0,   32'h14,  32'h0,        0,1,1,0, 32'h1111_1111, 32'hCAFEF00D, 2'd2, 1, 32'h12, 16'd6, 16'd2};
    tbl[15] = '{32'h4,   32'h10,  32'h1,        1,0,0,0, 32'h2222_2222, 32'h0,        2'd2, 1, 32'h12, 16'd6, 16'd2};
    tbl[16] = '{32'h4,   32'h10,  32'h0,        0,1,0,0, 32'h2222_2222, 32'hDEADBEEF, 2'd2, 1, 32'h12, 16'd6, 16'd2};

    rst_n = 1'b0;
    load_valid = 1'b0; load_sel = 1'b0; load_addr = 8'd0; load_data = 32'd0; load_last = 1'b0;
    idle_cpu();
    mem_re = 1'b1; mem_addr = 32'h10; pc = 32'h4;
    #2;
    chk("reset state", {30'd0, state}, 32'd0);
    chk("reset cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
    chk("reset load_ready", {31'd0, load_ready}, 32'd1);
    chk("reset fault", {31'd0, fault}, 32'd0);
    chk("reset fault_addr", fault_addr, 32'd0);
    chk("reset rd_count", {16'd0, rd_count}, 32'd0);
    chk("reset wr_count", {16'd0, wr_count}, 32'd0);
    chk("LOAD instr", instr, HALT);
    chk("LOAD mem_data_in", mem_data_in, 32'd0);
    @(negedge clk); rst_n = 1'b1; idle_cpu();

    load_beat(1'b0, 8'd0, 32'h1111_1111, 1'b0);
    load_beat(1'b0, 8'd1, 32'h2222_2222, 1'b0);
    load_beat(1'b1, 8'd5, 32'hCAFE_F00D, 1'b0);
    load_beat(1'b0, 8'd2, 32'h3333_3333, 1'b1);
    check_entered_run("first load");

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      pc = tbl[i].pc; mem_addr = tbl[i].addr; mem_data_out = tbl[i].wdata;
      mem_we = tbl[i].we; mem_re = tbl[i].re; cpu_halted = tbl[i].halt; reload = tbl[i].rld;
      #1;
      chk($sformatf("v%0d instr", i), instr, tbl[i].e_instr);
      chk($sformatf("v%0d mem_data_in", i), mem_data_in, tbl[i].e_mdi);
      @(posedge clk); #1;
      chk($sformatf("v%0d state", i), {30'd0, state}, {30'd0, tbl[i].e_state});
      chk($sformatf("v%0d fault", i), {31'd0, fault}, {31'd0, tbl[i].e_fault});
      chk($sformatf("v%0d fault_addr", i), fault_addr, tbl[i].e_faddr);
      chk($sformatf("v%0d rd_count", i), {16'd0, rd_count}, {16'd0, tbl[i].e_rd});
      chk($sformatf("v%0d wr_count", i), {16'd0, wr_count}, {16'd0, tbl[i].e_wr});
    end
    chk("DONE cpu_rst_n", {31'd0, cpu_rst_n}, 32'd1);

    @(negedge clk); idle_cpu(); reload = 1'b1;
    @(posedge clk); #1; reload = 1'b0;
    chk("reload state", {30'd0, state}, 32'd0);
    chk("reload cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
    chk("reload load_ready", {31'd0, load_ready}, 32'd1);
    chk("reload rd_count", {16'd0, rd_count}, 32'd0);
    chk("reload wr_count", {16'd0, wr_count}, 32'd0);
    chk("reload fault", {31'd0, fault}, 32'd0);
    pc = 32'h4; mem_re = 1'b1; mem_addr = 32'h10;
    #1;
    chk("reloaded instr", instr, HALT);
    chk("reloaded mem_data_in", mem_data_in, 32'd0);
    idle_cpu();

    load_beat(1'b0, 8'd3, 32'h4444_4444, 1'b1);
    check_entered_run("second load");
    pc = 32'hC; #1;
    chk("new imem word", instr, 32'h4444_4444);

    // Asynchronous reset in the middle of a RUN cycle.
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk("async rst state", {30'd0, state}, 32'd0);
    chk("async rst cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
    chk("async rst load_ready", {31'd0, load_ready}, 32'd1);
    chk("async rst fault", {31'd0, fault}, 32'd0);
    @(negedge clk); rst_n = 1'b1; idle_cpu();

    load_beat(1'b1, 8'd6, 32'h0BAD_F00D, 1'b1);
    check_entered_run("post-reset load");
    @(negedge clk);
    pc = 32'h4; mem_re = 1'b1; mem_addr = 32'h14;
    #1;
    chk("kept imem[1]", instr, 32'h2222_2222);
    chk("kept dmem[5]", mem_data_in, 32'hCAFE_F00D);
    @(negedge clk);
    pc = 32'hC; mem_addr = 32'h18;
    #1;
    chk("kept imem[3]", instr, 32'h4444_4444);
    chk("new dmem[6]", mem_data_in, 32'h0BAD_F00D);
    @(negedge clk);
    mem_addr = 32'h10;
    #1;
    chk("kept dmem[4]", mem_data_in, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    chk("post-reset rd_count", {16'd0, rd_count}, 32'd3);
    idle_cpu();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
